// File: rtl/uart_pkg.sv
// Shared UART types and constants, imported by the transmitter and receiver.
// UART_TX_PARITY_EN adds the PARITY state (and widens the state enum to 3 bits).
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    // Stop-period lengths in Ticks: 1, 1.5 and 2 stop bits
    localparam int STOP_1   = 16;
    localparam int STOP_1P5 = 24;
    localparam int STOP_2   = 32;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} uart_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
`endif

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, stop period, paced by 16x Tick.
// Optional UART_TX_PARITY_EN inserts a parity bit (even/odd chosen by ParityOdd).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int STOP_BIT_TICKS = STOP_1,
    parameter int OVERSAMPLE     = OVERSAMPLE_DEFAULT
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Tick,
    input  logic                 TxStart,
    input  logic [DATA_BITS-1:0] TxData,
`ifdef UART_TX_PARITY_EN
    input  logic                 ParityOdd,
`endif
    output logic                 Tx,
    output logic                 TxBusy,
    output logic                 TxDone
);

    localparam int TICK_MAX = (OVERSAMPLE > STOP_BIT_TICKS) ? OVERSAMPLE : STOP_BIT_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX);
    localparam int DATA_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_BIT_TICKS - 1);
    localparam logic [DATA_W-1:0] DATA_LAST = DATA_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [TICK_W-1:0]    tickCounter;
    logic [DATA_W-1:0]    dataCounter;
    logic [DATA_BITS-1:0] shiftReg;
`ifdef UART_TX_PARITY_EN
    logic                 parityBit;
`endif

    // Tx is loaded with the line level of the state being entered, so it stays a pure flop output
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state       <= IDLE;
            tickCounter <= '0;
            dataCounter <= '0;
            shiftReg    <= '0;
            Tx          <= 1'b1;
            TxBusy      <= 1'b0;
            TxDone      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parityBit   <= 1'b0;
`endif
        end else begin
            TxDone <= 1'b0;
            unique case (state)
                IDLE: begin
                    Tx <= 1'b1;
                    if (TxStart) begin
                        shiftReg    <= TxData;
                        tickCounter <= '0;
                        state       <= START;
                        Tx          <= 1'b0;
                        TxBusy      <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parityBit   <= (^TxData) ^ ParityOdd;
`endif
                    end
                end
                START: begin
                    if (Tick) begin
                        if (tickCounter == BIT_LAST) begin
                            tickCounter <= '0;
                            dataCounter <= '0;
                            state       <= DATA;
                            Tx          <= shiftReg[0];
                        end else begin
                            tickCounter <= tickCounter + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (Tick) begin
                        if (tickCounter == BIT_LAST) begin
                            shiftReg    <= shiftReg >> 1;
                            tickCounter <= '0;
                            if (dataCounter == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
                                Tx    <= parityBit;
`else
                                state <= STOP;
                                Tx    <= 1'b1;
`endif
                            end else begin
                                dataCounter <= dataCounter + 1'b1;
                                Tx          <= shiftReg[1];
                            end
                        end else begin
                            tickCounter <= tickCounter + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (Tick) begin
                        if (tickCounter == BIT_LAST) begin
                            tickCounter <= '0;
                            state       <= STOP;
                            Tx          <= 1'b1;
                        end else begin
                            tickCounter <= tickCounter + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (Tick) begin
                        if (tickCounter == STOP_LAST) begin
                            tickCounter <= '0;
                            state       <= IDLE;
                            Tx          <= 1'b1;
                            TxBusy      <= 1'b0;
                            TxDone      <= 1'b1;
                        end else begin
                            tickCounter <= tickCounter + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    Tx     <= 1'b1;
                    TxBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus queues expected frames, monitors decode the Tx line.
module tb_uart_transmitter;
    import uart_pkg::*;

    typedef struct {
        logic [7:0]  data;
        int unsigned nbits;
        int unsigned len;
        logic        par;
    } expFrame_t;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned LEN0 = 176;
    localparam int unsigned LEN1 = 176;
`else
    localparam int unsigned LEN0 = 160;
    localparam int unsigned LEN1 = 160;
`endif

    logic Clock, Tick;
    logic rstN0, TxStart0, Tx0, TxBusy0, TxDone0, ParityOdd0;
    logic [7:0] TxData0;
    logic rstN1, TxStart1, Tx1, TxBusy1, TxDone1, ParityOdd1;
    logic [6:0] TxData1;

    int unsigned passCount = 0;
    int unsigned checkCount = 0;
    int unsigned tickDiv = 0;
    int unsigned doneCount0 = 0;

    expFrame_t expQ0[$];
    expFrame_t expQ1[$];

    uart_transmitter dut0 (
        .Clock(Clock), .ResetN(rstN0), .Tick(Tick), .TxStart(TxStart0), .TxData(TxData0),
`ifdef UART_TX_PARITY_EN
        .ParityOdd(ParityOdd0),
`endif
        .Tx(Tx0), .TxBusy(TxBusy0), .TxDone(TxDone0)
    );

    uart_transmitter #(.DATA_BITS(7), .STOP_BIT_TICKS(STOP_2)) dut1 (
        .Clock(Clock), .ResetN(rstN1), .Tick(Tick), .TxStart(TxStart1), .TxData(TxData1),
`ifdef UART_TX_PARITY_EN
        .ParityOdd(ParityOdd1),
`endif
        .Tx(Tx1), .TxBusy(TxBusy1), .TxDone(TxDone1)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // One-Clock Tick every 4 Clocks
    initial begin
        Tick = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            tickDiv = (tickDiv + 1) % 4;
            Tick = (tickDiv == 0);
        end
    end

    task automatic check(input string nm, input int act, input int exp_);
        checkCount++;
        if (act == exp_) passCount++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_);
    endtask

    task automatic checkFrame(input string tag, input logic [511:0] s, input int unsigned n,
                              input expFrame_t e);
        int unsigned glitches, startBad, stopBad, stopBase;
        logic [7:0] d;
        glitches = 0; startBad = 0; stopBad = 0; d = '0;
        check({tag, " length"}, int'(n), int'(e.len));
        for (int unsigned i = 0; i < 16; i++) if (s[i] !== 1'b0) startBad++;
        check({tag, " start bit"}, int'(startBad), 0);
        for (int unsigned k = 0; k < e.nbits; k++) begin
            d[k] = s[16 + k*16 + 8];
            for (int unsigned j = 0; j < 16; j++)
                if (s[16 + k*16 + j] !== d[k]) glitches++;
        end
        check({tag, " data"}, int'(d), int'(e.data));
        check({tag, " bit stability"}, int'(glitches), 0);
`ifdef UART_TX_PARITY_EN
        check({tag, " parity"}, int'(s[(1 + e.nbits)*16 + 8]), int'(e.par));
        stopBase = (2 + e.nbits) * 16;
`else
        stopBase = (1 + e.nbits) * 16;
`endif
        for (int unsigned i = stopBase; i < n && i < 512; i++) if (s[i] !== 1'b1) stopBad++;
        check({tag, " stop level"}, int'(stopBad), 0);
    endtask

    // Monitors: record Tx at every Tick the DUT will consume while busy; judge the frame on TxDone
    logic [511:0] samp0, samp1;
    int unsigned sampN0 = 0, sampN1 = 0;

    always @(negedge Clock) begin
        if (!rstN0) sampN0 = 0;
        else begin
            if (Tick && TxBusy0 && sampN0 < 512) begin samp0[sampN0] = Tx0; sampN0++; end
            if (TxDone0) begin
                doneCount0++;
                check("dut0 TxDone has expected frame", int'(expQ0.size() != 0), 1);
                if (expQ0.size() != 0) checkFrame("dut0 frame", samp0, sampN0, expQ0.pop_front());
                sampN0 = 0;
            end
        end
    end

    always @(negedge Clock) begin
        if (!rstN1) sampN1 = 0;
        else begin
            if (Tick && TxBusy1 && sampN1 < 512) begin samp1[sampN1] = Tx1; sampN1++; end
            if (TxDone1) begin
                check("dut1 TxDone has expected frame", int'(expQ1.size() != 0), 1);
                if (expQ1.size() != 0) checkFrame("dut1 frame", samp1, sampN1, expQ1.pop_front());
                sampN1 = 0;
            end
        end
    end

    task automatic push0(input logic [7:0] d, input logic par);
        expQ0.push_back('{data: d, nbits: 8, len: LEN0, par: par});
    endtask

    task automatic issue0(input logic [7:0] d, input logic po, input logic par);
        TxData0 = d; ParityOdd0 = po; TxStart0 = 1'b1;
        push0(d, par);
        @(posedge Clock); #1;
        TxStart0 = 1'b0;
    endtask

    task automatic waitDone0(input int unsigned budget);
        bit got;
        got = 1'b0;
        for (int unsigned c = 0; c < budget && !got; c++) begin
            @(negedge Clock);
            if (TxDone0) got = 1'b1;
        end
        check("dut0 TxDone within budget", int'(got), 1);
    endtask

    task automatic waitDone1(input int unsigned budget);
        bit got;
        got = 1'b0;
        for (int unsigned c = 0; c < budget && !got; c++) begin
            @(negedge Clock);
            if (TxDone1) got = 1'b1;
        end
        check("dut1 TxDone within budget", int'(got), 1);
    endtask

    initial begin
        int unsigned ticksSeen, savedDone;
        rstN0 = 1'b0; rstN1 = 1'b0;
        TxStart0 = 1'b0; TxData0 = '0; ParityOdd0 = 1'b0;
        TxStart1 = 1'b0; TxData1 = '0; ParityOdd1 = 1'b0;
        repeat (3) @(posedge Clock);
        #1; rstN0 = 1'b1; rstN1 = 1'b1;
        @(negedge Clock);
        check("reset dut0 Tx", int'(Tx0), 1);
        check("reset dut0 TxBusy", int'(TxBusy0), 0);
        check("reset dut0 TxDone", int'(TxDone0), 0);
        check("reset dut1 Tx", int'(Tx1), 1);
        check("reset dut1 TxBusy", int'(TxBusy1), 0);

        // A5: 0 | 1 0 1 0 0 1 0 1 | 1
        @(posedge Clock); #1;
        issue0(8'hA5, 1'b0, 1'b0);
        waitDone0(1000);

        // 3C, then FF requested in the TxDone cycle: accepted on the next edge
        @(posedge Clock); #1;
        issue0(8'h3C, 1'b0, 1'b0);
        waitDone0(1000);
        TxData0 = 8'hFF; TxStart0 = 1'b1; push0(8'hFF, 1'b0);
        @(posedge Clock); #1;
        TxStart0 = 1'b0;
        @(negedge Clock);
        check("back-to-back TxBusy", int'(TxBusy0), 1);
        check("back-to-back start bit", int'(Tx0), 0);
        waitDone0(1000);

        // TxStart held, TxData changed mid-frame
        @(posedge Clock); #1;
        TxData0 = 8'h5A; TxStart0 = 1'b1; push0(8'h5A, 1'b0);
        repeat (160) @(posedge Clock);
        #1; TxData0 = 8'h00; push0(8'h00, 1'b0);
        waitDone0(1000);
        check("held TxBusy low in TxDone cycle", int'(TxBusy0), 0);
        @(negedge Clock);
        check("held restart TxBusy", int'(TxBusy0), 1);
        @(posedge Clock); #1;
        TxStart0 = 1'b0;
        waitDone0(1000);

        // Abort during data bit 3 (A5 bit 3 is 0)
        @(posedge Clock); #1;
        TxData0 = 8'hA5; TxStart0 = 1'b1;
        @(posedge Clock); #1;
        TxStart0 = 1'b0;
        ticksSeen = 0;
        for (int unsigned c = 0; c < 1000 && ticksSeen < 72; c++) begin
            @(negedge Clock);
            if (Tick && TxBusy0) ticksSeen++;
        end
        check("abort tick budget", int'(ticksSeen), 72);
        @(posedge Clock); #2;
        check("abort pre-reset Tx bit3", int'(Tx0), 0);
        savedDone = doneCount0;
        rstN0 = 1'b0;
        #1;
        check("abort Tx high", int'(Tx0), 1);
        check("abort TxBusy", int'(TxBusy0), 0);
        check("abort TxDone", int'(TxDone0), 0);
        repeat (2) @(posedge Clock);
        #1; rstN0 = 1'b1;
        repeat (20) @(negedge Clock);
        check("abort no TxDone", int'(doneCount0), int'(savedDone));
        @(posedge Clock); #1;
        issue0(8'hC3, 1'b0, 1'b0);
        waitDone0(1000);

`ifdef UART_TX_PARITY_EN
        // 07 has three ones: even parity bit 1, odd parity bit 0
        @(posedge Clock); #1;
        issue0(8'h07, 1'b0, 1'b1);
        waitDone0(1000);
        @(posedge Clock); #1;
        issue0(8'h07, 1'b1, 1'b0);
        waitDone0(1000);
`endif

        // 7 data bits, 2 stop bits
        @(posedge Clock); #1;
        TxData1 = 7'h41; ParityOdd1 = 1'b0; TxStart1 = 1'b1;
        expQ1.push_back('{data: 8'h41, nbits: 7, len: LEN1, par: 1'b0});
        @(posedge Clock); #1;
        TxStart1 = 1'b0;
        waitDone1(1000);

        repeat (4) @(negedge Clock);
        check("dut0 scoreboard drained", int'(expQ0.size()), 0);
        check("dut1 scoreboard drained", int'(expQ1.size()), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
